// File: rtl/adder_group_accum_if.sv
// Beat-in / result-out bundle for adder_group_accum; slave = accumulator, master = producer/consumer side.
interface adder_group_accum_if #(
    parameter int NUM_MACRO = 16,
    parameter int OUT_CH    = 512,
    parameter int PSUM_W    = 16,
    parameter int ACC_W     = 32
);
    localparam int BIT_OUT_CH = $clog2(OUT_CH);

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_first;
    logic                            in_last;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER;
    logic [NUM_MACRO-1:0]            MACRO_EN;
    logic [NUM_MACRO*PSUM_W-1:0]     PSUM;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_MACRO-1:0]            OUT_LANE_VALID;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] OUT_FILTER;
    logic [NUM_MACRO*ACC_W-1:0]      OUT_SUM;
    logic                            OUT_SAT;
    logic [NUM_MACRO*NUM_MACRO-1:0]  Adder_mask;

    modport slave (
        input  in_valid, in_first, in_last, WHICH_FILTER, MACRO_EN, PSUM, out_ready,
        output in_ready, out_valid, OUT_LANE_VALID, OUT_FILTER, OUT_SUM, OUT_SAT, Adder_mask
    );

    modport master (
        output in_valid, in_first, in_last, WHICH_FILTER, MACRO_EN, PSUM, out_ready,
        input  in_ready, out_valid, OUT_LANE_VALID, OUT_FILTER, OUT_SUM, OUT_SAT, Adder_mask
    );
endinterface

// File: rtl/adder_group_accum.sv
// Groups macro psums by filter into leader lanes and accumulates per window; last beat -> out_valid 2 edges later.
// A held output (out_valid && !out_ready) freezes the whole pipeline. Optional clamping: ADDER_GROUP_SAT_EN.
module adder_group_accum #(
    parameter int NUM_MACRO = 16,
    parameter int OUT_CH    = 512,
    parameter int PSUM_W    = 16,
    parameter int ACC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    adder_group_accum_if.slave  bus
);
    localparam int N  = NUM_MACRO;
    localparam int FW = $clog2(OUT_CH);

    typedef logic [N-1:0][N-1:0]      mask_t;
    typedef logic [N-1:0][FW-1:0]     filt_t;
    typedef logic [N-1:0][PSUM_W-1:0] psum_t;
    typedef logic [N-1:0][ACC_W-1:0]  acc_t;

    filt_t in_filt;
    mask_t new_mask;
    mask_t mask_q;
    filt_t filt_q;

    logic  s1_vld, s1_first, s1_last;
    psum_t s1_psum;
    mask_t s1_mask;
    filt_t s1_filt;

    logic  s2_last;
    mask_t s2_mask;
    filt_t s2_filt;
    acc_t  acc_q, acc_nxt;
    logic  sat_q, sat_nxt;

    logic         out_valid_q, out_sat_q;
    logic [N-1:0] out_lane_q;
    filt_t        out_filt_q;
    acc_t         out_sum_q;

    logic stall, accept;

    assign in_filt       = bus.WHICH_FILTER;
    assign stall         = out_valid_q && !bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = !stall && !rst;
    assign bus.out_valid      = out_valid_q;
    assign bus.OUT_LANE_VALID = out_lane_q;
    assign bus.OUT_FILTER     = out_filt_q;
    assign bus.OUT_SUM        = out_sum_q;
    assign bus.OUT_SAT        = out_sat_q;
    assign bus.Adder_mask     = mask_q;

    // A lane leads its group only if no lower enabled lane targets the same filter.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < N; i++) begin
            logic dup;
            dup = 1'b0;
            for (int j = 0; j < i; j++)
                dup = dup | (bus.MACRO_EN[j] && (in_filt[j] == in_filt[i]));
            for (int j = 0; j < N; j++)
                new_mask[i][j] = bus.MACRO_EN[i] && !dup && bus.MACRO_EN[j] &&
                                 (in_filt[j] == in_filt[i]);
        end
    end

    // Accumulator restarts on a new window or right after the previous window's last beat.
    always_comb begin
        logic clear;
        clear   = s1_first || s2_last;
        acc_nxt = '0;
        sat_nxt = clear ? 1'b0 : sat_q;
        for (int i = 0; i < N; i++) begin
            logic signed [ACC_W-1:0] gsum;
            logic signed [ACC_W-1:0] base;
            logic signed [ACC_W:0]   wide;
            gsum = '0;
            for (int j = 0; j < N; j++)
                if (s1_mask[i][j])
                    gsum = gsum + ACC_W'($signed(s1_psum[j]));
            base = clear ? '0 : $signed(acc_q[i]);
            wide = {base[ACC_W-1], base} + {gsum[ACC_W-1], gsum};
`ifdef ADDER_GROUP_SAT_EN
            if (wide[ACC_W] != wide[ACC_W-1]) begin
                acc_nxt[i] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                sat_nxt    = 1'b1;
            end else begin
                acc_nxt[i] = wide[ACC_W-1:0];
            end
`else
            acc_nxt[i] = wide[ACC_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            filt_q      <= '0;
            s1_vld      <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_psum     <= '0;
            s1_mask     <= '0;
            s1_filt     <= '0;
            s2_last     <= 1'b0;
            s2_mask     <= '0;
            s2_filt     <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_lane_q  <= '0;
            out_filt_q  <= '0;
            out_sum_q   <= '0;
        end else if (!stall) begin
            if (accept && bus.in_first) begin
                mask_q <= new_mask;
                filt_q <= in_filt;
            end
            s1_vld <= accept;
            if (accept) begin
                s1_psum  <= bus.PSUM;
                s1_first <= bus.in_first;
                s1_last  <= bus.in_last;
                s1_mask  <= bus.in_first ? new_mask : mask_q;
                s1_filt  <= bus.in_first ? in_filt : filt_q;
            end
            s2_last <= s1_vld && s1_last;
            if (s1_vld) begin
                s2_mask <= s1_mask;
                s2_filt <= s1_filt;
                acc_q   <= acc_nxt;
                sat_q   <= sat_nxt;
            end else if (s2_last) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end
            out_valid_q <= s2_last;
            if (s2_last) begin
                out_sat_q <= sat_q;
                for (int i = 0; i < N; i++) begin
                    out_lane_q[i] <= s2_mask[i][i];
                    out_filt_q[i] <= s2_mask[i][i] ? s2_filt[i] : '0;
                    out_sum_q[i]  <= s2_mask[i][i] ? acc_q[i] : '0;
                end
            end
        end
    end
endmodule

// File: doc/adder_group_accum.md
# adder_group_accum

Parametrised successor to the adder-mask generator in the macro output path. Per beat, groups the NUM_MACRO macro partial sums by target filter index (honouring a per-macro enable) and sums each group into its first-occurrence lane. Accumulates those group sums over a multi-beat window and emits one per-filter result set per window under a valid/ready handshake. Sits between the CIM macro array and the output-channel writeback.

## Interface
- NUM_MACRO, 16, number of macro lanes
- OUT_CH, 512, output-channel count; BIT_OUT_CH = $clog2(OUT_CH)
- PSUM_W, 16, signed partial-sum width per macro
- ACC_W, 32, signed accumulator width per lane (ACC_W >= PSUM_W + $clog2(NUM_MACRO))
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_first  in  1  first beat of window; captures mapping, clears accumulators
- in_last  in  1  last beat of window; triggers output
- WHICH_FILTER  in  NUM_MACRO*BIT_OUT_CH  filter index per lane, lane i at [i*BIT_OUT_CH +: BIT_OUT_CH]
- MACRO_EN  in  NUM_MACRO  lane participates in grouping
- PSUM  in  NUM_MACRO*PSUM_W  signed partial sum per lane
- out_valid  out  1  result set valid
- out_ready  in  1  result set consumed when out_valid && out_ready
- OUT_LANE_VALID  out  NUM_MACRO  lane i holds a group result
- OUT_FILTER  out  NUM_MACRO*BIT_OUT_CH  filter index of each valid lane, 0 otherwise
- OUT_SUM  out  NUM_MACRO*ACC_W  accumulated group sum per lane, 0 for non-valid lanes
- OUT_SAT  out  1  saturation occurred in window (0 unless ADDER_GROUP_SAT_EN)
- Adder_mask  out  NUM_MACRO*NUM_MACRO  registered mask of current window, row i at [i*NUM_MACRO +: NUM_MACRO]

## Operation
- Mask (computed on accepted in_first beat): leader[i] = MACRO_EN[i] && no j<i with MACRO_EN[j] && filter[j]==filter[i]; row i bit j = leader[i] && MACRO_EN[j] && filter[j]==filter[i]. Mask, leader vector and filter indices held until next in_first or reset.
- Stage 1 (accept edge): register PSUM, first, last, and the mask (new mask if first, else held).
- Stage 2: gsum[i] = sign-extended sum over j of row i bit j ? PSUM[j] : 0; acc[i] = (first ? 0 : acc[i]) + gsum[i].
- Stage 2 beat with last: OUT_* loaded from acc/held mask, out_valid set; acc cleared.
- Arithmetic: two's complement, wraps mod 2^ACC_W.
- Beats between windows without in_first reuse held mask; after reset mask is all-zero, so sums are 0 and OUT_LANE_VALID is 0.
- in_first mid-window: in-progress accumulation discarded, new window starts, no output for old window.
- in_first && in_last on one beat: single-beat window.
- All MACRO_EN = 0: OUT_LANE_VALID = 0, output still produced on in_last.

## Timing
- Reset (rst high at edge): out_valid, OUT_*, Adder_mask, acc, pipeline valids all 0; in_ready = 0 while rst high, 1 the cycle after.
- Latency: last beat accepted at edge t -> out_valid high after edge t+2.
- Stall = out_valid && !out_ready; whole pipeline holds; in_ready = !stall && !rst.
- Throughput: 1 beat/cycle with out_ready high; back-to-back single-beat windows give out_valid every cycle.
- Output held stable while out_valid && !out_ready.
- Reset mid-window or with out_valid high: all data dropped, no output.

## Configuration
- ADDER_GROUP_SAT_EN defined: each accumulation clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; OUT_SAT = OR of clamps over window, cleared by in_first.
- Undefined: wrap arithmetic, OUT_SAT tied 0.

## Test plan
- Filters {5,5,7,5,...} rest unique, all enabled, PSUM all 1, single-beat window -> lane0 sum 3 filter 5, lane2 sum 1, others leaders sum 1, lanes 1,3 invalid; out_valid at t+2.
- Same mapping, 4-beat window, PSUM lane j = j -> lane0 sum 4*(0+1+3)=16; Adder_mask row0 = 0x000B.
- MACRO_EN[0]=0 with filters {5,5,...} -> lane1 becomes leader of filter 5, lane0 invalid.
- out_ready low 5 cycles during stream -> in_ready low, outputs stable, no beat lost; sums match model.
- in_first mid-window then rst pulse mid-window -> no output for aborted windows; all outputs 0 after reset.
- With ADDER_GROUP_SAT_EN, ACC_W=20, PSUM = 0x7FFF on 16 lanes same filter, 4 beats -> OUT_SUM = 524287, OUT_SAT = 1; without macro -> wrapped value, OUT_SAT = 0.
